csi2_packet_tx: RTL and testbench



---
 rtl/csi2_packet_tx.sv | 226 ++++++++++++++++++++++
 tb/tb_csi2_packet_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_packet_tx.sv
// CSI-2 packetizer: turns DT/VC/WC commands plus a payload byte stream into
// lane bytes (sync, ECC-protected header, payload, CRC-16), with a forced idle gap.
module csi2_packet_tx #(
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [5:0]             cmd_dt,
    input  logic [1:0]             cmd_vc,
    input  logic [15:0]            cmd_wc,
    input  logic [8*NUM_LANES-1:0] pay_data,
    input  logic                   pay_valid,
    output logic                   pay_ready,
    output logic                   hs_valid,
    output logic [8*NUM_LANES-1:0] hs_data,
    output logic                   underflow,
    output logic                   cmd_error
);

    localparam int unsigned Lw      = 8 * NUM_LANES;
    localparam logic [15:0] HdrLast = 16'(4 / NUM_LANES - 1);
    localparam logic [15:0] CrcLast = 16'(2 / NUM_LANES - 1);
    localparam logic [15:0] GapLast = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] Step    = 16'(NUM_LANES);

    if (NUM_LANES != 1 && NUM_LANES != 2) begin : g_bad_lanes
        $fatal(1, "csi2_packet_tx: NUM_LANES must be 1 or 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $fatal(1, "csi2_packet_tx: GAP_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StSot,
        StHdr,
        StPayload,
        StCrc,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [7:0]      di_q, di_d;
    logic [15:0]     wc_q, wc_d;
    logic            long_q, long_d;
    logic [15:0]     crc_q, crc_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            pay_ready_q, pay_ready_d;
    logic            hs_valid_q, hs_valid_d;
    logic [Lw-1:0]   hs_data_q, hs_data_d;
    logic            underflow_q, underflow_d;
    logic            cmd_error_q, cmd_error_d;

    logic            cmd_long;
    logic            cmd_bad;
    logic [7:0]      ecc;
    logic [31:0]     hdr_word;
    logic [Lw-1:0]   beat;

    // Hamming parity P0..P5; each mask selects the header bits covered by one parity bit.
    function automatic logic [7:0] hdr_ecc(input logic [23:0] d);
        hdr_ecc = {2'b00,
                   ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                   ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    endfunction

    function automatic logic [15:0] crc_beat(input logic [15:0] crc, input logic [Lw-1:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < int'(Lw); i++) begin
            if (c[0] ^ b[i]) begin
                c = (c >> 1) ^ 16'h8408;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    assign cmd_long = (cmd_dt[5:4] != 2'b00);
    assign cmd_bad  = cmd_long && ((cmd_wc == 16'd0) || ((NUM_LANES == 2) && cmd_wc[0]));
    assign ecc      = hdr_ecc({wc_q, di_q});
    assign hdr_word = {ecc, wc_q[15:8], wc_q[7:0], di_q};
    // The burst cannot stall: a missing beat goes out as zeros and still feeds the CRC.
    assign beat     = pay_valid ? pay_data : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        di_d        = di_q;
        wc_d        = wc_q;
        long_d      = long_q;
        crc_d       = crc_q;
        cmd_ready_d = 1'b0;
        pay_ready_d = 1'b0;
        hs_valid_d  = 1'b0;
        hs_data_d   = '0;
        underflow_d = 1'b0;
        cmd_error_d = 1'b0;

        case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        cmd_error_d = 1'b1;
                    end else begin
                        di_d        = {cmd_vc, cmd_dt};
                        wc_d        = cmd_wc;
                        long_d      = cmd_long;
                        crc_d       = 16'hFFFF;
                        state_d     = StSot;
                        cmd_ready_d = 1'b0;
                        hs_valid_d  = 1'b1;
                        hs_data_d   = {NUM_LANES{8'hB8}};
                    end
                end
            end
            StSot: begin
                state_d    = StHdr;
                cnt_d      = '0;
                hs_valid_d = 1'b1;
                hs_data_d  = hdr_word[Lw-1:0];
            end
            StHdr: begin
                if (cnt_q != HdrLast) begin
                    cnt_d       = cnt_q + 16'd1;
                    hs_valid_d  = 1'b1;
                    hs_data_d   = Lw'(hdr_word >> ((32'(cnt_q) + 32'd1) * Lw));
                    // Outputs are registered, so the first beat is fetched one cycle early.
                    pay_ready_d = long_q && (cnt_d == HdrLast);
                end else if (long_q) begin
                    state_d     = StPayload;
                    cnt_d       = wc_q - Step;
                    hs_valid_d  = 1'b1;
                    hs_data_d   = beat;
                    underflow_d = !pay_valid;
                    crc_d       = crc_beat(crc_q, beat);
                    pay_ready_d = (cnt_d != 16'd0);
                end else begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            StPayload: begin
                if (cnt_q != 16'd0) begin
                    cnt_d       = cnt_q - Step;
                    hs_valid_d  = 1'b1;
                    hs_data_d   = beat;
                    underflow_d = !pay_valid;
                    crc_d       = crc_beat(crc_q, beat);
                    pay_ready_d = (cnt_d != 16'd0);
                end else begin
                    state_d    = StCrc;
                    cnt_d      = '0;
                    hs_valid_d = 1'b1;
                    hs_data_d  = crc_q[Lw-1:0];
                end
            end
            StCrc: begin
                if (cnt_q != CrcLast) begin
                    cnt_d      = cnt_q + 16'd1;
                    hs_valid_d = 1'b1;
                    hs_data_d  = crc_q[15 -: Lw];
                end else begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d     = StIdle;
                    cmd_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d     = StIdle;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            di_q        <= '0;
            wc_q        <= '0;
            long_q      <= 1'b0;
            crc_q       <= 16'hFFFF;
            cmd_ready_q <= 1'b1;
            pay_ready_q <= 1'b0;
            hs_valid_q  <= 1'b0;
            hs_data_q   <= '0;
            underflow_q <= 1'b0;
            cmd_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            di_q        <= di_d;
            wc_q        <= wc_d;
            long_q      <= long_d;
            crc_q       <= crc_d;
            cmd_ready_q <= cmd_ready_d;
            pay_ready_q <= pay_ready_d;
            hs_valid_q  <= hs_valid_d;
            hs_data_q   <= hs_data_d;
            underflow_q <= underflow_d;
            cmd_error_q <= cmd_error_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign pay_ready = pay_ready_q;
    assign hs_valid  = hs_valid_q;
    assign hs_data   = hs_data_q;
    assign underflow = underflow_q;
    assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_csi2_packet_tx.sv
// Directed bench for csi2_packet_tx: a 2-lane instance for most cases and a
// 1-lane instance for the single-lane header ordering.
module tb_csi2_packet_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [5:0]  cmd_dt;
    logic [1:0]  cmd_vc;
    logic [15:0] cmd_wc;
    logic [15:0] pay_data;
    logic        pay_valid, pay_ready;
    logic        hs_valid;
    logic [15:0] hs_data;
    logic        underflow, cmd_error;

    logic        cmd_valid1, cmd_ready1;
    logic [5:0]  cmd_dt1;
    logic [1:0]  cmd_vc1;
    logic [15:0] cmd_wc1;
    logic [7:0]  pay_data1;
    logic        pay_valid1, pay_ready1;
    logic        hs_valid1;
    logic [7:0]  hs_data1;
    logic        underflow1, cmd_error1;

    csi2_packet_tx #(.NUM_LANES(2), .GAP_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dt(cmd_dt), .cmd_vc(cmd_vc), .cmd_wc(cmd_wc),
        .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
        .hs_valid(hs_valid), .hs_data(hs_data),
        .underflow(underflow), .cmd_error(cmd_error)
    );

    csi2_packet_tx #(.NUM_LANES(1), .GAP_CYCLES(8)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_dt(cmd_dt1), .cmd_vc(cmd_vc1), .cmd_wc(cmd_wc1),
        .pay_data(pay_data1), .pay_valid(pay_valid1), .pay_ready(pay_ready1),
        .hs_valid(hs_valid1), .hs_data(hs_data1),
        .underflow(underflow1), .cmd_error(cmd_error1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] t2_bytes [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                                  8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                                  8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    logic [7:0] pay_bytes [64];

    logic [15:0] beats[$];
    int          gap_cnt, latency, uf_cnt;

    function automatic logic [31:0] beat_at(input int i);
        if (i < beats.size()) return {16'h0, beats[i]};
        return 32'hDEAD_BEEF;
    endfunction

    // Bit-serial reflected CRC-16 over the payload, with one beat replaced by zeros.
    function automatic logic [15:0] crc_model(input int nbytes, input int zero_beat);
        logic [15:0] c;
        logic [7:0]  d;
        c = 16'hFFFF;
        for (int b = 0; b < nbytes; b++) begin
            d = (b / 2 == zero_beat) ? 8'h00 : pay_bytes[b];
            for (int i = 0; i < 8; i++) begin
                if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
                else c = c >> 1;
            end
        end
        return c;
    endfunction

    // Issues one command on the 2-lane DUT, feeds payload on pay_ready and records the burst.
    task automatic run_pkt(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc,
                           input int drop_beat, input int rst_at);
        int bi;
        bi = 0;
        beats.delete();
        gap_cnt = 0;
        latency = -1;
        uf_cnt  = 0;
        cmd_valid = 1'b1;
        cmd_dt    = dt;
        cmd_vc    = vc;
        cmd_wc    = wc;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                cmd_valid = 1'b0;
                cmd_dt    = 6'h3F;
                cmd_vc    = 2'h3;
                cmd_wc    = 16'hFFFF;
            end
            if (rst_at >= 0 && k == rst_at + 1) begin
                check("rst hs_valid", {31'h0, hs_valid}, 32'h0);
                check("rst pay_ready", {31'h0, pay_ready}, 32'h0);
                check("rst cmd_ready", {31'h0, cmd_ready}, 32'h1);
                reset     = 1'b0;
                pay_valid = 1'b0;
                return;
            end
            if (hs_valid) beats.push_back(hs_data);
            else if (!cmd_ready) gap_cnt++;
            if (underflow) uf_cnt++;
            if (cmd_ready) begin
                latency = k;
                break;
            end
            if (k == rst_at) reset = 1'b1;
            pay_valid = 1'b0;
            pay_data  = '0;
            if (pay_ready) begin
                if (bi != drop_beat && bi < 32) begin
                    pay_valid = 1'b1;
                    pay_data  = {pay_bytes[2*bi+1], pay_bytes[2*bi]};
                end
                bi++;
            end
        end
        pay_valid = 1'b0;
    endtask

    task automatic check_fe(input string tag);
        check({tag, " len"}, beats.size(), 3);
        check({tag, " sot"}, beat_at(0), 32'hB8B8);
        check({tag, " hdr0"}, beat_at(1), 32'h0001);
        check({tag, " hdr1"}, beat_at(2), 32'h0700);
        check({tag, " gap"}, gap_cnt, 8);
        check({tag, " latency"}, latency, 11);
    endtask

    task automatic check_long(input string tag, input int drop, input logic [15:0] crc);
        logic [15:0] exp;
        check({tag, " len"}, beats.size(), 16);
        check({tag, " sot"}, beat_at(0), 32'hB8B8);
        check({tag, " hdr0"}, beat_at(1), 32'h182A);
        check({tag, " hdr1"}, beat_at(2), 32'h1300);
        for (int i = 0; i < 12; i++) begin
            exp = (i == drop) ? 16'h0000 : {pay_bytes[2*i+1], pay_bytes[2*i]};
            check($sformatf("%s beat%0d", tag, i), beat_at(3 + i), {16'h0, exp});
        end
        check({tag, " crc"}, beat_at(15), {16'h0, crc});
        check({tag, " gap"}, gap_cnt, 8);
        check({tag, " latency"}, latency, 24);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) pay_bytes[i] = (i < 24) ? t2_bytes[i] : 8'h00;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_dt = '0; cmd_vc = '0; cmd_wc = '0;
        pay_data = '0; pay_valid = 1'b0;
        cmd_valid1 = 1'b0; cmd_dt1 = '0; cmd_vc1 = '0; cmd_wc1 = '0;
        pay_data1 = '0; pay_valid1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("reset pay_ready", {31'h0, pay_ready}, 32'h0);
        check("reset hs_valid", {31'h0, hs_valid}, 32'h0);
        check("reset hs_data", {16'h0, hs_data}, 32'h0);
        check("reset underflow", {31'h0, underflow}, 32'h0);
        check("reset cmd_error", {31'h0, cmd_error}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Frame End, two lanes
        run_pkt(6'h01, 2'd0, 16'd0, -1, -1);
        check_fe("t1");

        // Generic short packet, vc=1, data field 0x1234, ECC 0x19
        run_pkt(6'h08, 2'd1, 16'h1234, -1, -1);
        check("t1b len", beats.size(), 3);
        check("t1b hdr0", beat_at(1), 32'h3448);
        check("t1b hdr1", beat_at(2), 32'h1912);
        check("t1b latency", latency, 11);

        // Long packet with the reference payload
        run_pkt(6'h2A, 2'd0, 16'd24, -1, -1);
        check_long("t2", -1, 16'h00F0);
        check("t2 underflow", uf_cnt, 0);

        // Same packet with the fifth beat missing
        run_pkt(6'h2A, 2'd0, 16'd24, 4, -1);
        check_long("t3", 4, crc_model(24, 4));
        check("t3 underflow", uf_cnt, 1);

        // Illegal long word counts
        cmd_valid = 1'b1; cmd_dt = 6'h2A; cmd_vc = 2'd0; cmd_wc = 16'd0;
        @(posedge clk);
        #1;
        check("t4 wc0 cmd_error", {31'h0, cmd_error}, 32'h1);
        check("t4 wc0 hs_valid", {31'h0, hs_valid}, 32'h0);
        check("t4 wc0 cmd_ready", {31'h0, cmd_ready}, 32'h1);
        cmd_wc = 16'd3;
        @(posedge clk);
        #1;
        check("t4 wc3 cmd_error", {31'h0, cmd_error}, 32'h1);
        check("t4 wc3 hs_valid", {31'h0, hs_valid}, 32'h0);
        check("t4 wc3 cmd_ready", {31'h0, cmd_ready}, 32'h1);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t4 idle cmd_error", {31'h0, cmd_error}, 32'h0);
        check("t4 idle hs_valid", {31'h0, hs_valid}, 32'h0);

        // Reset in the middle of a 64-byte payload, then a clean Frame End
        run_pkt(6'h2A, 2'd0, 16'd64, -1, 6);
        run_pkt(6'h01, 2'd0, 16'd0, -1, -1);
        check_fe("t5");

        // Single lane Frame Start
        cmd_valid1 = 1'b1; cmd_dt1 = 6'h00; cmd_vc1 = 2'd0; cmd_wc1 = 16'd0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) cmd_valid1 = 1'b0;
            if (k < 5) begin
                check($sformatf("t6 byte%0d", k), {23'h0, hs_valid1, hs_data1},
                      {23'h0, 1'b1, (k == 0) ? 8'hB8 : 8'h00});
            end else if (k == 5) begin
                check("t6 gap", {31'h0, hs_valid1}, 32'h0);
            end
            if (cmd_ready1) begin
                check("t6 latency", k, 13);
                break;
            end
            if (k == 39) check("t6 latency", k, 13);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
